// File: rtl/hazard_pkg.sv
// Shared constants and types for the pipeline hazard sequencer.
package hazard_pkg;

  localparam int CNT_W           = 4;
  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;

  // A tuse of 3 can never be below any tnew, so unused operands never stall.
  localparam logic [1:0] TUSE_NONE = 2'd3;

  typedef enum logic {MD_IDLE, MD_BUSY} md_state_e;

  function automatic logic raw_hit(input logic [4:0] src, input logic [1:0] tuse,
                                   input logic [4:0] wa, input logic [1:0] tnew);
    return (src != 5'd0) && (src == wa) && (tuse < tnew);
  endfunction

endpackage

// File: rtl/md_busy_timer.sv
// Multiply/divide busy timer: loads a cycle count when an MD op leaves E, counts down to idle.
module md_busy_timer
  import hazard_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic isdiv,
  input  logic int_req,
  output logic md_busy
);

  logic [CNT_W-1:0] cnt, cnt_nxt;
  md_state_e        state;

  always_ff @(posedge clk) begin
    if (reset) cnt <= '0;
    else       cnt <= cnt_nxt;
  end

  // A start flushed by int_req never loads; an already running op keeps counting.
  always_comb begin
    cnt_nxt = cnt;
    if (start && !int_req)
      cnt_nxt = isdiv ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
    else if (cnt != '0)
      cnt_nxt = cnt - CNT_W'(1);
  end

  always_comb begin
    state   = (cnt != '0) ? MD_BUSY : MD_IDLE;
    md_busy = (state == MD_BUSY);
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline sequencer: data/MD/eret stalls, ID/EX bubbles and exception flush.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] d_rs,
  input  logic [4:0] d_rt,
  input  logic [1:0] d_tuse_rs,
  input  logic [1:0] d_tuse_rt,
  input  logic [4:0] e_wa,
  input  logic [4:0] m_wa,
  input  logic [1:0] e_tnew,
  input  logic [1:0] m_tnew,
  input  logic       d_is_md,
  input  logic       e_md_start,
  input  logic       e_md_isdiv,
  input  logic       d_eret,
  input  logic       e_mtc0_epc,
  input  logic       m_mtc0_epc,
  input  logic       int_req,
  output logic       stall,
  output logic       clr_e,
  output logic       flush,
  output logic       md_busy
);

  logic data_hz, md_hz, eret_hz, stall_raw;

  md_busy_timer #(
    .MULT_CYCLES(MULT_CYCLES),
    .DIV_CYCLES (DIV_CYCLES)
  ) u_timer (
    .clk    (clk),
    .reset  (reset),
    .start  (e_md_start),
    .isdiv  (e_md_isdiv),
    .int_req(int_req),
    .md_busy(md_busy)
  );

  always_comb begin
    data_hz   = raw_hit(d_rs, d_tuse_rs, e_wa, e_tnew) |
                raw_hit(d_rt, d_tuse_rt, e_wa, e_tnew) |
                raw_hit(d_rs, d_tuse_rs, m_wa, m_tnew) |
                raw_hit(d_rt, d_tuse_rt, m_wa, m_tnew);
    md_hz     = d_is_md & (md_busy | e_md_start);
    eret_hz   = d_eret & (e_mtc0_epc | m_mtc0_epc);
    stall_raw = data_hz | md_hz | eret_hz;
    // An exception flush overrides every stall source.
    stall     = stall_raw & ~int_req;
    clr_e     = stall_raw & ~int_req;
    flush     = int_req;
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: driver pushes model predictions, monitor pops and compares.
module tb_hazard_ctrl;
  import hazard_pkg::*;

  localparam int MC = 5;
  localparam int DC = 10;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic [4:0] d_rs, d_rt, e_wa, m_wa;
  logic [1:0] d_tuse_rs, d_tuse_rt, e_tnew, m_tnew;
  logic       d_is_md, e_md_start, e_md_isdiv, d_eret, e_mtc0_epc, m_mtc0_epc, int_req;
  logic       stall, clr_e, flush, md_busy;

  hazard_ctrl #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk(clk), .reset(reset),
    .d_rs(d_rs), .d_rt(d_rt), .d_tuse_rs(d_tuse_rs), .d_tuse_rt(d_tuse_rt),
    .e_wa(e_wa), .m_wa(m_wa), .e_tnew(e_tnew), .m_tnew(m_tnew),
    .d_is_md(d_is_md), .e_md_start(e_md_start), .e_md_isdiv(e_md_isdiv),
    .d_eret(d_eret), .e_mtc0_epc(e_mtc0_epc), .m_mtc0_epc(m_mtc0_epc),
    .int_req(int_req),
    .stall(stall), .clr_e(clr_e), .flush(flush), .md_busy(md_busy)
  );

  typedef struct {
    logic       reset;
    logic [4:0] d_rs, d_rt, e_wa, m_wa;
    logic [1:0] d_tuse_rs, d_tuse_rt, e_tnew, m_tnew;
    logic       d_is_md, e_md_start, e_md_isdiv, d_eret, e_mtc0_epc, m_mtc0_epc, int_req;
  } stim_t;

  typedef struct {
    logic stall, clr_e, flush, md_busy;
    int   cyc;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   busy_end = -1;   // last cycle in which the MD unit is still busy
  logic done = 1'b0;

  function automatic stim_t idle();
    stim_t s;
    s.reset = 0; s.d_rs = 0; s.d_rt = 0; s.e_wa = 0; s.m_wa = 0;
    s.d_tuse_rs = TUSE_NONE; s.d_tuse_rt = TUSE_NONE; s.e_tnew = 0; s.m_tnew = 0;
    s.d_is_md = 0; s.e_md_start = 0; s.e_md_isdiv = 0; s.d_eret = 0;
    s.e_mtc0_epc = 0; s.m_mtc0_epc = 0; s.int_req = 0;
    return s;
  endfunction

  function automatic logic needs_wait(input logic [4:0] r, input logic [1:0] tu,
                                      input logic [4:0] wa, input logic [1:0] tn);
    return (r != 0) && (r == wa) && (tu < tn);
  endfunction

  task automatic apply(input stim_t s);
    exp_t e;
    logic raw;
    logic busy_now;
    @(posedge clk); #1;
    reset = s.reset; d_rs = s.d_rs; d_rt = s.d_rt; e_wa = s.e_wa; m_wa = s.m_wa;
    d_tuse_rs = s.d_tuse_rs; d_tuse_rt = s.d_tuse_rt; e_tnew = s.e_tnew; m_tnew = s.m_tnew;
    d_is_md = s.d_is_md; e_md_start = s.e_md_start; e_md_isdiv = s.e_md_isdiv;
    d_eret = s.d_eret; e_mtc0_epc = s.e_mtc0_epc; m_mtc0_epc = s.m_mtc0_epc;
    int_req = s.int_req;
    busy_now = (cyc <= busy_end);
    raw = needs_wait(s.d_rs, s.d_tuse_rs, s.e_wa, s.e_tnew) ||
          needs_wait(s.d_rt, s.d_tuse_rt, s.e_wa, s.e_tnew) ||
          needs_wait(s.d_rs, s.d_tuse_rs, s.m_wa, s.m_tnew) ||
          needs_wait(s.d_rt, s.d_tuse_rt, s.m_wa, s.m_tnew) ||
          (s.d_is_md && (busy_now || s.e_md_start)) ||
          (s.d_eret && (s.e_mtc0_epc || s.m_mtc0_epc));
    e.stall   = raw && !s.int_req;
    e.clr_e   = raw && !s.int_req;
    e.flush   = s.int_req;
    e.md_busy = busy_now;
    e.cyc     = cyc;
    q.push_back(e);
    if (s.reset)                           busy_end = cyc;
    else if (s.e_md_start && !s.int_req)   busy_end = cyc + (s.e_md_isdiv ? DC : MC);
    cyc++;
  endtask

  task automatic chk(input string nm, input logic act, input logic req, input int c);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%b expected=%b", nm, c, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (q.size() != 0) begin
      exp_t e;
      e = q.pop_front();
      chk("stall",   stall,   e.stall,   e.cyc);
      chk("clr_e",   clr_e,   e.clr_e,   e.cyc);
      chk("flush",   flush,   e.flush,   e.cyc);
      chk("md_busy", md_busy, e.md_busy, e.cyc);
    end
    if (done) begin
      total++;
      if (q.size() != 0) begin
        bad++;
        $display("FAIL drain left=%0d expected=0", q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
    end
  end

  initial begin
    stim_t s;
    s = idle();
    reset = 1; d_rs = 0; d_rt = 0; e_wa = 0; m_wa = 0;
    d_tuse_rs = TUSE_NONE; d_tuse_rt = TUSE_NONE; e_tnew = 0; m_tnew = 0;
    d_is_md = 0; e_md_start = 0; e_md_isdiv = 0; d_eret = 0;
    e_mtc0_epc = 0; m_mtc0_epc = 0; int_req = 0;
    repeat (2) @(posedge clk);

    apply(idle());   // reset state: all outputs 0

    // load-use then the producer moving to M
    s = idle(); s.e_wa = 8; s.e_tnew = 2; s.d_rs = 8; s.d_tuse_rs = 1; apply(s);
    s = idle(); s.m_wa = 8; s.m_tnew = 1; s.d_rs = 8; s.d_tuse_rs = 1; apply(s);
    // $0 never stalls
    s = idle(); s.d_rs = 0; s.e_wa = 0; s.e_tnew = 2; s.d_tuse_rs = 0; apply(s);
    // rt path against M
    s = idle(); s.m_wa = 5; s.m_tnew = 2; s.d_rt = 5; s.d_tuse_rt = 0; apply(s);

    // mult then div timing with an MD instruction waiting in D
    for (int k = 0; k < 2; k++) begin
      s = idle(); s.d_is_md = 1; s.e_md_start = 1; s.e_md_isdiv = (k == 1); apply(s);
      s = idle(); s.d_is_md = 1;
      repeat ((k == 1) ? DC + 2 : MC + 2) apply(s);
    end

    // interrupt beats load-use; flushed MD start never loads
    s = idle(); s.e_wa = 8; s.e_tnew = 2; s.d_rs = 8; s.d_tuse_rs = 1; s.int_req = 1; apply(s);
    s = idle(); s.e_md_start = 1; s.int_req = 1; apply(s);
    s = idle(); s.d_is_md = 1; repeat (3) apply(s);

    // interrupt while busy keeps the timer running
    s = idle(); s.e_md_start = 1; apply(s);
    s = idle(); s.int_req = 1; s.d_is_md = 1; apply(s);
    s = idle(); s.d_is_md = 1; repeat (6) apply(s);

    // eret waits on an EPC write
    s = idle(); s.d_eret = 1; s.m_mtc0_epc = 1; apply(s);
    s = idle(); s.d_eret = 1; s.e_mtc0_epc = 1; apply(s);
    s = idle(); s.d_eret = 1; apply(s);

    // reset three cycles into a divide
    s = idle(); s.e_md_start = 1; s.e_md_isdiv = 1; apply(s);
    s = idle(); repeat (2) apply(s);
    s = idle(); s.reset = 1; s.d_is_md = 1; apply(s);
    s = idle(); s.d_is_md = 1; repeat (4) apply(s);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      s.reset      = ($urandom_range(0, 63) == 0);
      s.d_rs       = 5'($urandom_range(0, 3));
      s.d_rt       = 5'($urandom_range(0, 3));
      s.e_wa       = 5'($urandom_range(0, 3));
      s.m_wa       = 5'($urandom_range(0, 3));
      s.d_tuse_rs  = 2'($urandom_range(0, 3));
      s.d_tuse_rt  = 2'($urandom_range(0, 3));
      s.e_tnew     = 2'($urandom_range(0, 3));
      s.m_tnew     = 2'($urandom_range(0, 3));
      s.d_is_md    = ($urandom_range(0, 2) == 0);
      s.e_md_start = ($urandom_range(0, 9) == 0);
      s.e_md_isdiv = 1'($urandom_range(0, 1));
      s.d_eret     = ($urandom_range(0, 3) == 0);
      s.e_mtc0_epc = ($urandom_range(0, 3) == 0);
      s.m_mtc0_epc = ($urandom_range(0, 3) == 0);
      s.int_req    = ($urandom_range(0, 11) == 0);
      apply(s);
    end

    @(posedge clk); #1;
    done = 1'b1;
  end

endmodule
